pulse_arbiter: RTL and testbench

Multi-input single-pulse scheduler for the button/pulse subsystem. It converts up to N_REQ button inputs into one-cycle output pulses on a single shared pulse channel. Each input's active-going edge becomes one pending event. Pending events are granted round-robin, with a programmable minimum spacing, and the granted source index is reported alongside each pulse. It sits between the synchronized button inputs and the downstream logic that consumes one pulse at a time.

---
 rtl/pulse_arbiter.sv | 150 +++++++++++++++
 tb/tb_pulse_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_arbiter.sv
// Turns active-going button edges into one-cycle pulses on a shared channel,
// granted round-robin with a programmable minimum idle gap between pulses.
module pulse_arbiter #(
    parameter int   N_REQ        = 4,
    parameter int   GAP_CYCLES   = 3,
    parameter logic ACTIVE_LEVEL = 1'b1,
    localparam int  ID_W         = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_REQ-1:0] button_i,
    output logic             pulse_o,
    output logic [ID_W-1:0]  id_o,
    output logic [N_REQ-1:0] pending_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [N_REQ-1:0] PREV_RST = {N_REQ{~ACTIVE_LEVEL}};
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
    localparam logic [7:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] prev_q, prev_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  last_g_q, last_g_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic             pulse_q, pulse_d;
    logic             overflow_q, overflow_d;

    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] grant_mask;
    logic             grant_en;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand_idx;

    // prev resets to the inactive level so a button held through reset still yields one event
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_edge
        assign rise[gi] = (button_i[gi] == ACTIVE_LEVEL) && (prev_q[gi] != ACTIVE_LEVEL);
    end
    assign prev_d = button_i;

    // Round-robin search starting just after the last granted index
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_idx = ID_W'((int'(last_g_q) + i) % N_REQ);
            if (!grant_found && pending_q[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a grant always looks at the registered pending flags
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        grant_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_en = 1'b1;
                    state_d  = PULSE;
                end
            end
            PULSE: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else if (|pending_q) begin
                    grant_en = 1'b1;
                    state_d  = PULSE;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    if (|pending_q) begin
                        grant_en = 1'b1;
                        state_d  = PULSE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / bookkeeping logic; a rise on the grant edge re-queues instead of overflowing
    always_comb begin
        grant_mask = '0;
        if (grant_en) begin
            grant_mask[grant_idx] = 1'b1;
        end
        pending_d  = (pending_q & ~grant_mask) | rise;
        overflow_d = |(rise & pending_q & ~grant_mask);
        last_g_d   = grant_en ? grant_idx : last_g_q;
        pulse_d    = (state_d == PULSE);
        id_d       = grant_en ? grant_idx : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q     <= PREV_RST;
            pending_q  <= '0;
            last_g_q   <= LAST_RST;
            gap_cnt_q  <= 8'd0;
            pulse_q    <= 1'b0;
            id_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            last_g_q   <= last_g_d;
            gap_cnt_q  <= gap_cnt_d;
            pulse_q    <= pulse_d;
            id_q       <= id_d;
            overflow_q <= overflow_d;
        end
    end

    assign pulse_o    = pulse_q;
    assign id_o       = id_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Bench for pulse_arbiter: one instance with GAP_CYCLES=3 and one with GAP_CYCLES=0,
// expected pulses (id and cycle) queued at stimulus time and matched as pulses appear.
module tb_pulse_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn3, btn0;
    logic       pulse3, pulse0, ovf3, ovf0;
    logic [1:0] id3, id0;
    logic [3:0] pend3, pend0;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] id;
        int         cyc;
    } exp_t;

    exp_t exp3[$];
    exp_t exp0[$];

    pulse_arbiter #(.N_REQ(4), .GAP_CYCLES(3), .ACTIVE_LEVEL(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .button_i(btn3),
        .pulse_o(pulse3), .id_o(id3), .pending_o(pend3), .overflow_o(ovf3)
    );

    pulse_arbiter #(.N_REQ(4), .GAP_CYCLES(0), .ACTIVE_LEVEL(1'b1)) dut_gap0 (
        .clk_i(clk), .rst_n_i(rst_n), .button_i(btn0),
        .pulse_o(pulse0), .id_o(id0), .pending_o(pend0), .overflow_o(ovf0)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: every pulse is matched against the head of its instance's queue
    initial forever begin
        exp_t e;
        @(negedge clk);
        checks++;
        if (pulse3) begin
            if (exp3.size() == 0) begin
                failures++;
                $display("FAIL gap3_pulse: unexpected pulse id=%0d cycle=%0d, required no pulse", id3, cyc);
            end else begin
                e = exp3.pop_front();
                if (id3 !== e.id || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL gap3_pulse: got id=%0d cycle=%0d, required id=%0d cycle=%0d", id3, cyc, e.id, e.cyc);
                end else begin
                    $display("gap3 pulse id=%0d cycle=%0d", id3, cyc);
                end
            end
        end else if (id3 !== 2'd0) begin
            failures++;
            $display("FAIL gap3_id_idle: got id=%0d, required 0", id3);
        end
        checks++;
        if (pulse0) begin
            if (exp0.size() == 0) begin
                failures++;
                $display("FAIL gap0_pulse: unexpected pulse id=%0d cycle=%0d, required no pulse", id0, cyc);
            end else begin
                e = exp0.pop_front();
                if (id0 !== e.id || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL gap0_pulse: got id=%0d cycle=%0d, required id=%0d cycle=%0d", id0, cyc, e.id, e.cyc);
                end else begin
                    $display("gap0 pulse id=%0d cycle=%0d", id0, cyc);
                end
            end
        end else if (id0 !== 2'd0) begin
            failures++;
            $display("FAIL gap0_id_idle: got id=%0d, required 0", id0);
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        btn3  = 4'b0000;
        btn0  = 4'b0000;
        repeat (2) @(negedge clk);
        exp3.delete();
        exp0.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn3  = 4'b0000;
        btn0  = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({pulse3, id3, pend3, ovf3} !== 8'h00) begin
            failures++;
            $display("FAIL reset_gap3: got pulse=%b id=%0d pend=%b ovf=%b, required all 0", pulse3, id3, pend3, ovf3);
        end
        checks++;
        if ({pulse0, id0, pend0, ovf0} !== 8'h00) begin
            failures++;
            $display("FAIL reset_gap0: got pulse=%b id=%0d pend=%b ovf=%b, required all 0", pulse0, id0, pend0, ovf0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset check done at cycle %0d", cyc);
    endtask

    task automatic test_single_press();
        int t;
        int pend_cycles;
        apply_reset();
        @(negedge clk);
        t = cyc;
        btn3 = 4'b0100;
        exp3.push_back('{2'd2, t + 2});
        pend_cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (pend3[2]) pend_cycles++;
            if (i == 1) begin
                checks++;
                if (pend3 !== 4'b0100) begin
                    failures++;
                    $display("FAIL single_pending: got %b, required 0100", pend3);
                end
            end
        end
        checks++;
        if (pend_cycles != 1) begin
            failures++;
            $display("FAIL single_pend_len: got %0d cycles, required 1", pend_cycles);
        end
        checks++;
        if (exp3.size() != 0) begin
            failures++;
            $display("FAIL single_missing: got %0d pulses outstanding, required 0", exp3.size());
        end
        btn3 = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int t;
        apply_reset();
        @(negedge clk);
        t = cyc;
        btn3 = 4'b1011;
        exp3.push_back('{2'd0, t + 2});
        exp3.push_back('{2'd1, t + 6});
        exp3.push_back('{2'd3, t + 10});
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (pend3 !== 4'b1011) begin
                    failures++;
                    $display("FAIL simul_pending: got %b, required 1011", pend3);
                end
            end
        end
        checks++;
        if (exp3.size() != 0) begin
            failures++;
            $display("FAIL simul_missing: got %0d pulses outstanding, required 0", exp3.size());
        end
        btn3 = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fairness();
        int t;
        apply_reset();
        @(negedge clk);
        t = cyc;
        btn3 = 4'b0011;
        exp3.push_back('{2'd0, t + 2});
        exp3.push_back('{2'd1, t + 6});
        exp3.push_back('{2'd0, t + 10});
        exp3.push_back('{2'd1, t + 14});
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 2) btn3[0] = 1'b0;
            if (c == 3) btn3[0] = 1'b1;
            if (c == 6) btn3[1] = 1'b0;
            if (c == 7) btn3[1] = 1'b1;
        end
        checks++;
        if (exp3.size() != 0) begin
            failures++;
            $display("FAIL fair_missing: got %0d pulses outstanding, required 0", exp3.size());
        end
        btn3 = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overflow_requeue();
        int t;
        int ovf_cycles;
        apply_reset();
        @(negedge clk);
        t = cyc;
        btn3 = 4'b0011;
        exp3.push_back('{2'd0, t + 2});
        exp3.push_back('{2'd1, t + 6});
        exp3.push_back('{2'd1, t + 10});
        ovf_cycles = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ovf3) ovf_cycles++;
            if (c == 3) begin
                checks++;
                if (ovf3 !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_flag: got %b at cycle %0d, required 1", ovf3, cyc);
                end
            end
            if (c == 6) begin
                checks++;
                if (pend3[1] !== 1'b1) begin
                    failures++;
                    $display("FAIL requeue_pending: got %b, required 1", pend3[1]);
                end
            end
            if (c == 1) btn3[1] = 1'b0;
            if (c == 2) btn3[1] = 1'b1;
            if (c == 4) btn3[1] = 1'b0;
            if (c == 5) btn3[1] = 1'b1;
        end
        checks++;
        if (ovf_cycles != 1) begin
            failures++;
            $display("FAIL ovf_count: got %0d overflow cycles, required 1", ovf_cycles);
        end
        checks++;
        if (exp3.size() != 0) begin
            failures++;
            $display("FAIL ovf_missing: got %0d pulses outstanding, required 0", exp3.size());
        end
        btn3 = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gap_zero();
        int t;
        apply_reset();
        @(negedge clk);
        t = cyc;
        btn0 = 4'b0111;
        exp0.push_back('{2'd0, t + 2});
        exp0.push_back('{2'd1, t + 3});
        exp0.push_back('{2'd2, t + 4});
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (pend0 !== 4'b0111) begin
                    failures++;
                    $display("FAIL gap0_pending: got %b, required 0111", pend0);
                end
            end
        end
        checks++;
        if (exp0.size() != 0) begin
            failures++;
            $display("FAIL gap0_missing: got %0d pulses outstanding, required 0", exp0.size());
        end
        btn0 = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_gap();
        int t;
        int r;
        apply_reset();
        @(negedge clk);
        t = cyc;
        btn3 = 4'b0111;
        exp3.push_back('{2'd0, t + 2});
        repeat (3) @(negedge clk);
        checks++;
        if (pend3 !== 4'b0110) begin
            failures++;
            $display("FAIL midgap_pending: got %b, required 0110", pend3);
        end
        #2;
        rst_n = 1'b0;
        btn3  = 4'b1000;
        #1;
        checks++;
        if ({pulse3, id3, pend3, ovf3} !== 8'h00) begin
            failures++;
            $display("FAIL midgap_async: got pulse=%b id=%0d pend=%b ovf=%b, required all 0", pulse3, id3, pend3, ovf3);
        end
        repeat (2) @(negedge clk);
        exp3.delete();
        r = cyc;
        rst_n = 1'b1;
        exp3.push_back('{2'd3, r + 2});
        repeat (20) @(negedge clk);
        checks++;
        if (exp3.size() != 0) begin
            failures++;
            $display("FAIL midgap_missing: got %0d pulses outstanding, required 0", exp3.size());
        end
        btn3 = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        btn3  = 4'b0000;
        btn0  = 4'b0000;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_fairness();
        test_overflow_requeue();
        test_gap_zero();
        test_reset_mid_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
